// File: rtl/spi_shift_pkg.sv
// Shared definitions for the SPI frame shifter: FSM state encoding and default frame width.
package spi_shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_frame_shifter_if.sv
// Frame-level bus of the SPI frame shifter; rx_parity exists only with SPI_FRAME_SHIFTER_PARITY_EN.
interface spi_frame_shifter_if
  import spi_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // start is a request taken only while idle (busy=0, done=0); it is never queued.
  // shift_en qualifies serial_in for one bit; done is a one-cycle completion strobe.
  logic             start;
  logic             lsb_first;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_in;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
  logic             busy;
  logic             done;
  state_t           fsm_state;
`ifdef SPI_FRAME_SHIFTER_PARITY_EN
  logic             rx_parity;
`endif

  modport master (
    output start, lsb_first, parallel_in, shift_en, serial_in,
    input  serial_out, parallel_out, busy, done, fsm_state
`ifdef SPI_FRAME_SHIFTER_PARITY_EN
    , input rx_parity
`endif
  );

  modport slave (
    input  start, lsb_first, parallel_in, shift_en, serial_in,
    output serial_out, parallel_out, busy, done, fsm_state
`ifdef SPI_FRAME_SHIFTER_PARITY_EN
    , output rx_parity
`endif
  );

endinterface

// File: rtl/shift_bit_counter.sv
// Bit counter for one frame; last flags the tick that carries the final bit.
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/spi_frame_shifter.sv
// Full-duplex SPI frame shifter with selectable bit order.
// Optional rx_parity output is enabled by defining SPI_FRAME_SHIFTER_PARITY_EN.
module spi_frame_shifter
  import spi_shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                clear,
  spi_frame_shifter_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] rx_word;
  logic             order_lsb;
  logic             accept;
  logic             tick;
  logic             cnt_last;

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clear (clear),
    .load  (accept),
    .inc   (tick),
    .last  (cnt_last)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    tick     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          tick = 1'b1;
          if (cnt_last) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Incoming bit enters at the end opposite to the one being transmitted.
  assign sr_shifted = order_lsb ? {bus.serial_in, sr[WIDTH-1:1]}
                                : {sr[WIDTH-2:0], bus.serial_in};

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      sr        <= '0;
      order_lsb <= 1'b0;
      rx_word   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sr        <= bus.parallel_in;
        order_lsb <= bus.lsb_first;
      end else if (tick) begin
        sr <= sr_shifted;
      end
      if (tick && cnt_last) rx_word <= sr_shifted;
    end
  end

`ifdef SPI_FRAME_SHIFTER_PARITY_EN
  logic rx_par;

  always_ff @(posedge clk) begin
    if (clear) begin
      rx_par <= 1'b0;
    end else if (tick && cnt_last) begin
      rx_par <= ^sr_shifted;
    end
  end

  assign bus.rx_parity = rx_par;
`endif

  assign bus.busy         = (state == SHIFT);
  assign bus.done         = (state == DONE);
  assign bus.serial_out   = bus.busy ? (order_lsb ? sr[0] : sr[WIDTH-1]) : 1'b0;
  assign bus.parallel_out = rx_word;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Scoreboard bench for spi_frame_shifter (WIDTH=8); parity checks follow SPI_FRAME_SHIFTER_PARITY_EN.
module tb_spi_frame_shifter;
  import spi_shift_pkg::*;

  localparam int W = 8;

  logic clk;
  logic clear;
  int   errors;
  int   checks;

  logic [W-1:0] exp_q[$];
  logic         exp_bit_q[$];

  spi_frame_shifter_if #(.WIDTH(W)) bus ();

  spi_frame_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // monitor: serial bits on every shift tick, received word on every done
  always @(negedge clk) begin
    if (!clear && bus.busy && bus.shift_en) begin
      if (exp_bit_q.size() == 0) begin
        check("unexpected_shift_tick", 32'd1, 32'd0);
      end else begin
        check("serial_out_bit", {31'd0, bus.serial_out}, {31'd0, exp_bit_q.pop_front()});
      end
    end
    if (!clear && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] w;
        w = exp_q.pop_front();
        check("parallel_out", {24'd0, bus.parallel_out}, {24'd0, w});
        check("done_busy_low", {31'd0, bus.busy}, 32'd0);
        check("done_serial_out_low", {31'd0, bus.serial_out}, 32'd0);
`ifdef SPI_FRAME_SHIFTER_PARITY_EN
        check("rx_parity", {31'd0, bus.rx_parity}, {31'd0, ^w});
`endif
      end
    end
  end

  // driver: one frame starting in the current cycle; returns in the done cycle
  task automatic run_frame(input logic [W-1:0] din, input logic lsb, input logic [W-1:0] rx,
                           input bit loopback, input int gap, input bit restart,
                           input int exp_busy, input string name);
    int  cyc, busy_cyc, done_cyc, b, k;
    bit  seen, en;
    logic bitv;
    for (int i = 0; i < W; i++) exp_bit_q.push_back(lsb ? din[i] : din[W-1-i]);
    exp_q.push_back(loopback ? din : rx);
    bus.start       = 1'b1;
    bus.parallel_in = din;
    bus.lsb_first   = lsb;
    bus.shift_en    = 1'b1;
    bus.serial_in   = 1'b1;
    cyc = 0; busy_cyc = 0; done_cyc = 0; b = 0; k = 0; seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = restart;
      if (restart) begin
        bus.parallel_in = ~din;
        bus.lsb_first   = ~lsb;
      end
      if (bus.done) begin
        seen         = 1'b1;
        done_cyc     = cyc;
        bus.shift_en = 1'b0;
      end else if (bus.busy) begin
        busy_cyc++;
        en = (b % gap == 0);
        b++;
        if (loopback)    bitv = bus.serial_out;
        else if (k >= W) bitv = 1'b0;
        else             bitv = lsb ? rx[k] : rx[W-1-k];
        bus.shift_en  = en;
        bus.serial_in = en ? bitv : ~bitv;
        if (en) k++;
      end else begin
        bus.shift_en = 1'b0;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_busy_cycles"}, busy_cyc, exp_busy);
    check({name, "_done_latency"}, done_cyc, exp_busy + 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start       = 1'b0;
    bus.lsb_first   = 1'b0;
    bus.parallel_in = '0;
    bus.shift_en    = 1'b0;
    bus.serial_in   = 1'b0;
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_serial_out", {31'd0, bus.serial_out}, 32'd0);
    check("rst_parallel_out", {24'd0, bus.parallel_out}, 32'd0);
    check("rst_state", {30'd0, bus.fsm_state}, {30'd0, IDLE});
    clear = 1'b0;
    @(posedge clk); #1;

    run_frame(8'hA5, 1'b0, 8'h00, 1'b1, 1, 1'b0, 8, "msb_loop_a5");
    @(posedge clk); #1;
    run_frame(8'h01, 1'b1, 8'h00, 1'b0, 1, 1'b0, 8, "lsb_01");
    @(posedge clk); #1;
    run_frame(8'h5A, 1'b0, 8'h3C, 1'b0, 3, 1'b0, 22, "gap3_3c");
    @(posedge clk); #1;
    run_frame(8'hC3, 1'b0, 8'h96, 1'b0, 1, 1'b1, 8, "restart_96");
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("start_not_queued", {31'd0, bus.busy}, 32'd0);
    run_frame(8'h00, 1'b1, 8'h07, 1'b0, 1, 1'b0, 8, "lsb_rx_07");
    @(posedge clk); #1;
    run_frame(8'h81, 1'b0, 8'h03, 1'b0, 2, 1'b0, 15, "gap2_rx_03");
    @(posedge clk); #1;

    // abort after three ticks; clear also wins over start and shift_en
    exp_bit_q.push_back(1'b1);
    exp_bit_q.push_back(1'b1);
    exp_bit_q.push_back(1'b1);
    bus.start       = 1'b1;
    bus.parallel_in = 8'hFF;
    bus.lsb_first   = 1'b0;
    bus.shift_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.shift_en  = 1'b1;
      bus.serial_in = 1'b1;
    end
    @(posedge clk); #1;
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    clear        = 1'b1;
    bus.start    = 1'b1;
    bus.shift_en = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_serial_out", {31'd0, bus.serial_out}, 32'd0);
    check("abort_parallel_out", {24'd0, bus.parallel_out}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_bits_consumed", exp_bit_q.size(), 32'd0);
    clear        = 1'b0;
    bus.start    = 1'b0;
    bus.shift_en = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_still_idle", {31'd0, bus.busy}, 32'd0);

    run_frame(8'h3C, 1'b1, 8'hA5, 1'b0, 1, 1'b0, 8, "post_abort_a5");
    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_bit_q_drained", exp_bit_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_shifter.md
SPI_FRAME_SHIFTER -- requirements
Module: spi_frame_shifter

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), bit-counter width; derived only, never overridden.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 clear  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  frame request; sampled in IDLE only.
REQ-006 lsb_first  input  1  bit order (1 = LSB first); latched on accepted start.
REQ-007 parallel_in  input  WIDTH  transmit word; loaded on accepted start.
REQ-008 shift_en  input  1  shift tick; one bit moves per cycle it is high in SHIFT.
REQ-009 serial_in  input  1  receive bit; captured on each shift tick.
REQ-010 serial_out  output  1  current transmit bit.
REQ-011 parallel_out  output  WIDTH  last completed received word.
REQ-012 busy  output  1  high while in SHIFT.
REQ-013 done  output  1  one-cycle pulse at frame end.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE + start=1: load shift register with parallel_in, latch lsb_first, counter=0, next state SHIFT; otherwise stay IDLE.
REQ-016 A shift_en coincident with the accepted start SHALL be ignored (load only, no shift).
REQ-017 busy SHALL rise the cycle after the accepted start.
REQ-018 serial_out SHALL be shift register bit WIDTH-1 (MSB-first) or bit 0 (LSB-first) while busy, and 0 otherwise.
REQ-019 SHIFT + shift_en=1, MSB-first: register shifts left, serial_in enters bit 0.
REQ-020 SHIFT + shift_en=1, LSB-first: register shifts right, serial_in enters bit WIDTH-1.
REQ-021 SHIFT + shift_en=0: register, counter and state hold; gaps of any length are legal.
REQ-022 Each shift tick in SHIFT SHALL increment the counter.
REQ-023 The tick with counter==WIDTH-1 SHALL perform the final shift and move to DONE.
REQ-024 DONE SHALL last exactly one cycle: done=1, busy=0, next state IDLE.
REQ-025 On entry to DONE, parallel_out SHALL take the full received word; it holds until the next DONE.
REQ-026 Net latency from the final shift tick to done SHALL be one cycle; a back-to-back start is accepted no earlier than the cycle after done.
REQ-027 start in SHIFT or DONE SHALL be ignored and not queued.
REQ-028 shift_en, serial_in and lsb_first changes outside their sampling points SHALL have no effect.

Reset
REQ-029 clear=1 SHALL force IDLE, shift register=0, counter=0, latched order=0, parallel_out=0, serial_out=0, busy=0, done=0 on the next edge.
REQ-030 clear SHALL take priority over start and shift_en in every state, including mid-frame.
REQ-031 A frame aborted by clear SHALL produce no done pulse and SHALL leave parallel_out=0.

Configuration
REQ-032 Macro SPI_FRAME_SHIFTER_PARITY_EN SHALL add output rx_parity (1 bit).
REQ-033 With the macro: rx_parity = XOR of the received word, updated with parallel_out and cleared by clear.
REQ-034 Without the macro: no rx_parity port and no parity logic.

Structure
REQ-035 Shared package spi_shift_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-036 Sub-module shift_bit_counter (CNT_W wide; inputs clear, load, inc; output last) SHALL implement the counter and WIDTH-1 detection.

Verification
REQ-037 WIDTH=8, MSB-first, parallel_in=0xA5, serial_out looped to serial_in, shift_en every cycle -> serial_out 1,0,1,0,0,1,0,1; done 9 cycles after start; parallel_out=0xA5.
REQ-038 LSB-first, parallel_in=0x01, serial_in=0 -> first serial_out bit 1, then seven 0s; parallel_out=0x00.
REQ-039 MSB-first, shift_en every third cycle, serial_in pattern 0x3C -> parallel_out=0x3C; busy high for 22 cycles; exactly one done pulse.
REQ-040 start re-pulsed on every busy cycle of a frame -> no reload, single done; next start after done accepted.
REQ-041 clear asserted after 3 shift ticks -> next edge: busy=0, serial_out=0, parallel_out=0, no done.
REQ-042 With SPI_FRAME_SHIFTER_PARITY_EN, received 0x07 -> rx_parity=1; received 0x03 -> rx_parity=0.
